// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, receiver state encodings and the
// baud divider helper used by both the receive and transmit paths.
package uart_rx_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef logic [UART_DATA_BITS-1:0] uart_data_t;

   // Receiver FSM encodings, kept as plain constants so older netlists and
   // the transmitter can share the same codes.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   // Clocks per oversample tick; never allowed to drop below one.
   function automatic int unsigned calc_div(input int clk_freq, input int baud,
                                            input int oversample);
      int unsigned d;
      d = int'(clk_freq / (baud * oversample));
      if (d < 1) d = 1;
      return d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver host-side bundle: serial line in, byte handshake and status out.
interface uart_rx_if;
   import uart_rx_pkg::*;

   logic       rxd;
   logic       rd_ack;
   uart_data_t rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   // Host / line side.
   modport master (
      output rxd,
      output rd_ack,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy
   );

   // Receiver side.
   modport slave (
      input  rxd,
      input  rd_ack,
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks.
module uart_baud_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clkin,
   input  logic rst,
   output logic tick
);

   logic [31:0] cnt;

   assign tick = (cnt == DIV - 1);

   // Free-running 0..DIV-1 counter, wraps on the tick clock.
   always_ff @(posedge clkin) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, start-glitch
// rejection, framing-error detection and a valid/ack byte handshake.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | line high, waiting for a falling edge
//   START    | confirming the start bit at half a bit time
//   DATA     | sampling 8 data bits, LSB first, one per bit time
//   STOP     | sampling the stop bit; high delivers the byte
//   BREAK    | stop bit was low; wait for the line to return high
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input logic     clkin,
   input logic     rst,
   uart_rx_if.slave bus
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(UART_DATA_BITS);

   localparam logic [SW-1:0] SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SCNT_FULL = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

   logic          tick;
   logic          rxd_m;
   logic          rxd_s;
   logic [2:0]    state;
   logic [SW-1:0] scnt;
   logic [BW-1:0] bidx;
   uart_data_t    shift;
   logic          done;
   logic          frame_err_q;
   logic          overrun_q;
   uart_data_t    rx_data_q;
   logic          rx_valid_q;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clkin (clkin),
      .rst   (rst),
      .tick  (tick)
   );

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge clkin) begin
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= bus.rxd;
         rxd_s <= rxd_m;
      end
   end

   // Frame FSM; advances only on oversample ticks. done/frame_err are
   // single-clock strobes regardless of the tick rate.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state       <= ST_IDLE;
         scnt        <= '0;
         bidx        <= '0;
         shift       <= '0;
         done        <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         done        <= 1'b0;
         frame_err_q <= 1'b0;
         if (tick) begin
            case (state)
               ST_IDLE: begin
                  if (!rxd_s) begin
                     state <= ST_START;
                     scnt  <= '0;
                  end
               end
               ST_START: begin
                  if (scnt == SCNT_HALF) begin
                     scnt  <= '0;
                     bidx  <= '0;
                     // A start that has vanished by mid-bit is a glitch.
                     state <= rxd_s ? ST_IDLE : ST_DATA;
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
               ST_DATA: begin
                  if (scnt == SCNT_FULL) begin
                     scnt  <= '0;
                     shift <= {rxd_s, shift[UART_DATA_BITS-1:1]};
                     if (bidx == BIT_LAST) begin
                        state <= ST_STOP;
                     end else begin
                        bidx <= bidx + 1'b1;
                     end
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
               ST_STOP: begin
                  if (scnt == SCNT_FULL) begin
                     scnt <= '0;
                     if (rxd_s) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end else begin
                        frame_err_q <= 1'b1;
                        state       <= ST_BREAK;
                     end
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
               ST_BREAK: begin
                  if (rxd_s) begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Output byte and handshake; a completing byte always wins over rd_ack.
   always_ff @(posedge clkin) begin
      if (rst) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (done) begin
            rx_data_q  <= shift;
            rx_valid_q <= 1'b1;
            overrun_q  <= rx_valid_q && !bus.rd_ack;
         end else if (bus.rd_ack) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state != ST_IDLE);

endmodule
